// File: rtl/core_pkg.sv
// Shared types for the pipelined ARM core's hazard logic.
package core_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // M-stage result has priority because it is the youngest value.
    function automatic fwd_sel_t fwd_select(
        input logic match_m,
        input logic wr_m,
        input logic match_w,
        input logic wr_w
    );
        if (match_m && wr_m) begin
            return FWD_MEM;
        end else if (match_w && wr_w) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: forwarding selects, load-use/PC-write stalls and flushes,
// plus saturating stall/flush event counters.
module hazard_unit
    import core_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Match_1E_M,
    input  logic             Match_1E_W,
    input  logic             Match_2E_M,
    input  logic             Match_2E_W,
    input  logic             Match_12D_E,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             BranchTakenE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    logic r_reg_write_m;
    logic r_reg_write_w;
    logic r_pc_src_m;
    logic r_pc_src_w;

    logic w_ldr_stall_d;
    logic w_pc_wr_pending_f;
    fwd_sel_t w_fwd_a;
    fwd_sel_t w_fwd_b;

    // E/M/W stages never stall, so these copies advance every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write_m <= 1'b0;
            r_reg_write_w <= 1'b0;
            r_pc_src_m    <= 1'b0;
            r_pc_src_w    <= 1'b0;
        end else begin
            r_reg_write_m <= RegWriteE;
            r_reg_write_w <= r_reg_write_m;
            r_pc_src_m    <= PCSrcE;
            r_pc_src_w    <= r_pc_src_m;
        end
    end

    always_comb begin
        w_fwd_a = fwd_select(Match_1E_M, r_reg_write_m, Match_1E_W, r_reg_write_w);
        w_fwd_b = fwd_select(Match_2E_M, r_reg_write_m, Match_2E_W, r_reg_write_w);
    end

    assign w_ldr_stall_d     = Match_12D_E & MemtoRegE & RegWriteE;
    assign w_pc_wr_pending_f = PCSrcD | PCSrcE | r_pc_src_m;

    assign ForwardAE = w_fwd_a;
    assign ForwardBE = w_fwd_b;
    assign StallD    = w_ldr_stall_d;
    assign StallF    = w_ldr_stall_d | w_pc_wr_pending_f;
    assign FlushD    = w_pc_wr_pending_f | r_pc_src_w | BranchTakenE;
    assign FlushE    = w_ldr_stall_d | BranchTakenE;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (StallD),
        .count (StallCount)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (FlushD),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// stimulus against a behavioural model of the hazard rules.
module tb_hazard_unit;

    localparam int unsigned CW = 3;
    localparam int unsigned CMAX = (1 << CW) - 1;

    localparam logic [10:0] I_BR  = 11'h001;
    localparam logic [10:0] I_PCE = 11'h002;
    localparam logic [10:0] I_PCD = 11'h004;
    localparam logic [10:0] I_MEM = 11'h008;
    localparam logic [10:0] I_RWE = 11'h010;
    localparam logic [10:0] I_M12 = 11'h020;
    localparam logic [10:0] I_M2W = 11'h040;
    localparam logic [10:0] I_M2M = 11'h080;
    localparam logic [10:0] I_M1W = 11'h100;
    localparam logic [10:0] I_M1M = 11'h200;
    localparam logic [10:0] I_RST = 11'h400;

    logic clk = 1'b0;
    logic reset, m1m, m1w, m2m, m2w, m12, rwe, mre, pcd, pce, bre;
    logic [1:0]    fa, fb;
    logic          sf, sd, fd, fe;
    logic [CW-1:0] sc, fc;

    int n_cmp = 0;
    int n_bad = 0;

    // Model history: index 0 = one cycle ago (M), index 1 = two cycles ago (W).
    logic    rw_hist [2];
    logic    pc_hist [2];
    int      m_sc, m_fc;

    always #5 clk = ~clk;

    hazard_unit #(
        .CNT_W (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Match_1E_M   (m1m),
        .Match_1E_W   (m1w),
        .Match_2E_M   (m2m),
        .Match_2E_W   (m2w),
        .Match_12D_E  (m12),
        .RegWriteE    (rwe),
        .MemtoRegE    (mre),
        .PCSrcD       (pcd),
        .PCSrcE       (pce),
        .BranchTakenE (bre),
        .ForwardAE    (fa),
        .ForwardBE    (fb),
        .StallF       (sf),
        .StallD       (sd),
        .FlushD       (fd),
        .FlushE       (fe),
        .StallCount   (sc),
        .FlushCount   (fc)
    );

    function automatic logic [13:0] obs();
        return {fa, fb, sf, sd, fd, fe, sc, fc};
    endfunction

    function automatic logic [13:0] pack(input logic [1:0] a, input logic [1:0] b,
                                         input logic [3:0] ctl, input int s, input int f);
        return {a, b, ctl, CW'(s), CW'(f)};
    endfunction

    function automatic logic [13:0] model_out();
        logic [1:0] a, b;
        logic ldr, pend;
        a = (m1m && rw_hist[0]) ? 2'd2 : (m1w && rw_hist[1]) ? 2'd1 : 2'd0;
        b = (m2m && rw_hist[0]) ? 2'd2 : (m2w && rw_hist[1]) ? 2'd1 : 2'd0;
        ldr  = m12 & mre & rwe;
        pend = pcd | pce | pc_hist[0];
        return pack(a, b, {ldr | pend, ldr, pend | pc_hist[1] | bre, ldr | bre}, m_sc, m_fc);
    endfunction

    task automatic drive(input logic [10:0] v);
        @(negedge clk);
        {reset, m1m, m1w, m2m, m2w, m12, rwe, mre, pcd, pce, bre} = v;
        #1;
    endtask

    task automatic tick();
        logic [13:0] e;
        e = model_out();
        @(posedge clk);
        if (reset) begin
            rw_hist = '{1'b0, 1'b0};
            pc_hist = '{1'b0, 1'b0};
            m_sc = 0;
            m_fc = 0;
        end else begin
            rw_hist[1] = rw_hist[0];
            rw_hist[0] = rwe;
            pc_hist[1] = pc_hist[0];
            pc_hist[0] = pce;
            if (e[8] && m_sc < CMAX) m_sc++;
            if (e[7] && m_fc < CMAX) m_fc++;
        end
    endtask

    task automatic do_reset();
        drive(I_RST);
        tick();
        drive('0);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (obs() !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %b want %b", obs(), 14'd0);
        end
    endtask

    task automatic test_forward();
        do_reset();
        drive(I_RWE);
        tick();
        drive(I_M1M | I_M1W);
        n_cmp++;
        if (obs() !== pack(2'b10, 2'b00, 4'b0, 0, 0)) begin
            n_bad++;
            $display("FAIL fwd_a_mem: got %b want %b", obs(), pack(2'b10, 2'b00, 4'b0, 0, 0));
        end
        tick();
        drive(I_M1W);
        n_cmp++;
        if (obs() !== pack(2'b01, 2'b00, 4'b0, 0, 0)) begin
            n_bad++;
            $display("FAIL fwd_a_wb: got %b want %b", obs(), pack(2'b01, 2'b00, 4'b0, 0, 0));
        end
        tick();
        drive(I_RWE);
        tick();
        drive(I_M2M | I_M2W);
        n_cmp++;
        if (obs() !== pack(2'b00, 2'b10, 4'b0, 0, 0)) begin
            n_bad++;
            $display("FAIL fwd_b_mem: got %b want %b", obs(), pack(2'b00, 2'b10, 4'b0, 0, 0));
        end
        tick();
        do_reset();
        drive('0);
        tick();
        drive(I_M1M | I_M1W);
        n_cmp++;
        if (obs() !== 14'd0) begin
            n_bad++;
            $display("FAIL fwd_no_write_m: got %b want %b", obs(), 14'd0);
        end
        tick();
        drive(I_M1W);
        n_cmp++;
        if (obs() !== 14'd0) begin
            n_bad++;
            $display("FAIL fwd_no_write_w: got %b want %b", obs(), 14'd0);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(I_MEM | I_RWE | I_M12);
        n_cmp++;
        if (obs() !== pack(2'b00, 2'b00, 4'b1101, 0, 0)) begin
            n_bad++;
            $display("FAIL load_use: got %b want %b", obs(), pack(2'b00, 2'b00, 4'b1101, 0, 0));
        end
        tick();
        drive('0);
        n_cmp++;
        if (obs() !== pack(2'b00, 2'b00, 4'b0, 1, 0)) begin
            n_bad++;
            $display("FAIL load_use_count: got %b want %b", obs(), pack(2'b00, 2'b00, 4'b0, 1, 0));
        end
        tick();
    endtask

    task automatic test_pc_write();
        logic [10:0] stim [4] = '{I_PCD, I_PCE, 11'd0, 11'd0};
        logic [3:0]  ctl  [4] = '{4'b1010, 4'b1010, 4'b1010, 4'b0010};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(stim[i]);
            n_cmp++;
            if (obs() !== pack(2'b00, 2'b00, ctl[i], 0, i)) begin
                n_bad++;
                $display("FAIL pc_write_c%0d: got %b want %b", i, obs(),
                         pack(2'b00, 2'b00, ctl[i], 0, i));
            end
            tick();
        end
        drive('0);
        n_cmp++;
        if (obs() !== pack(2'b00, 2'b00, 4'b0, 0, 4)) begin
            n_bad++;
            $display("FAIL pc_write_done: got %b want %b", obs(), pack(2'b00, 2'b00, 4'b0, 0, 4));
        end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        drive(I_BR | I_M12 | I_MEM | I_RWE);
        n_cmp++;
        if (obs() !== pack(2'b00, 2'b00, 4'b1111, 0, 0)) begin
            n_bad++;
            $display("FAIL branch_load_use: got %b want %b", obs(),
                     pack(2'b00, 2'b00, 4'b1111, 0, 0));
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(I_MEM | I_RWE | I_M12);
            n_cmp++;
            if (sc !== CW'((i > int'(CMAX)) ? CMAX : i)) begin
                n_bad++;
                $display("FAIL sat_c%0d: got %0d want %0d", i, sc,
                         (i > int'(CMAX)) ? CMAX : i);
            end
            tick();
        end
        drive(I_RST);
        n_cmp++;
        if (sc !== CW'(CMAX)) begin
            n_bad++;
            $display("FAIL sat_hold: got %0d want %0d", sc, CMAX);
        end
        tick();
        drive('0);
        n_cmp++;
        if (sc !== '0) begin
            n_bad++;
            $display("FAIL sat_reset: got %0d want 0", sc);
        end
        tick();
    endtask

    task automatic test_random();
        logic [10:0] v;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            v = 11'($urandom_range(0, 1023));
            if ($urandom_range(0, 39) == 0) v = v | I_RST;
            // Bias toward load-use and branch-free cycles so counters move both ways.
            if ($urandom_range(0, 2) == 0) v = v & ~(I_PCD | I_PCE | I_BR);
            drive(v);
            n_cmp++;
            if (obs() !== model_out()) begin
                n_bad++;
                $display("FAIL random_c%0d in=%b: got %b want %b", i, v, obs(), model_out());
            end
            tick();
        end
    endtask

    initial begin
        rw_hist = '{1'b0, 1'b0};
        pc_hist = '{1'b0, 1'b0};
        m_sc = 0;
        m_fc = 0;
        {reset, m1m, m1w, m2m, m2w, m12, rwe, mre, pcd, pce, bre} = I_RST;
        test_reset();
        test_forward();
        test_load_use();
        test_pc_write();
        test_branch();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Hazard controller for the 5-stage pipelined ARM core; it sits at the other end of the datapath's hazard interface.
- Consumes the datapath's register-match flags and the controller's per-stage write and PC-source flags.
- Produces the forwarding selects and the stall/flush controls the datapath takes.
- Keeps its own M/W-stage copies of RegWrite and PCSrc, plus saturating stall and flush event counters for performance debug.

Parameters:
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- Match_1E_M  in  1  WA3M == RA1E
- Match_1E_W  in  1  WA3W == RA1E
- Match_2E_M  in  1  WA3M == RA2E
- Match_2E_W  in  1  WA3W == RA2E
- Match_12D_E  in  1  WA3E equals RA1D or RA2D
- RegWriteE  in  1  condition-qualified register write of the E-stage instruction
- MemtoRegE  in  1  E-stage instruction is a load
- PCSrcD  in  1  D-stage instruction writes PC (unqualified)
- PCSrcE  in  1  condition-qualified PC write in E
- BranchTakenE  in  1  branch resolved taken in E
- ForwardAE  out  2  SrcA select: 00 rd1E, 01 ResultW, 10 ALUOutM
- ForwardBE  out  2  SrcB/WriteData select, same encoding
- StallF  out  1  hold PC register
- StallD  out  1  hold D instruction register
- FlushD  out  1  clear D instruction register
- FlushE  out  1  clear E-stage control register (controller side)
- StallCount  out  CNT_W  cycles with StallD=1, saturating
- FlushCount  out  CNT_W  cycles with FlushD=1, saturating

Behaviour:
- All state updates on rising clk. reset is synchronous, active-high.
- Internal pipeline flops, all reset to 0, no enable (the E/M/W stages are never stalled):
  - RegWriteM_q <= RegWriteE; RegWriteW_q <= RegWriteM_q.
  - PCSrcM_q <= PCSrcE; PCSrcW_q <= PCSrcM_q.
- Forwarding (combinational from Match inputs and internal flops):
  - ForwardAE = 10 if Match_1E_M & RegWriteM_q; else 01 if Match_1E_W & RegWriteW_q; else 00.
  - ForwardBE is the same, using Match_2E_M and Match_2E_W.
  - When M and W both match, M has priority (youngest value).
  - Encoding 11 is never driven.
- Load-use: ldrStallD = Match_12D_E & MemtoRegE & RegWriteE.
- PC write pending: PCWrPendingF = PCSrcD | PCSrcE | PCSrcM_q.
- Outputs:
  - StallD = ldrStallD.
  - StallF = ldrStallD | PCWrPendingF.
  - FlushD = PCWrPendingF | PCSrcW_q | BranchTakenE.
  - FlushE = ldrStallD | BranchTakenE.
- Simultaneous events:
  - Load-use with BranchTakenE: FlushE=1 and FlushD=1. StallD is still asserted, but the flush dominates in the datapath register.
  - PCSrcW_q with a new ldrStallD: both stall and flush are asserted.
- Counters, reset to 0:
  - StallCount increments on each cycle with StallD=1 (not on the reset cycle); holds at 2^CNT_W−1.
  - FlushCount does the same for FlushD.
- Reset values: all internal flops and counters are 0. With all inputs 0 after reset, every output is 0.
- Reset mid-operation: pending PCSrcM_q/PCSrcW_q and RegWrite copies are discarded next cycle, so forwarding reverts to 00 and flushes from pending PC writes stop.
- Latency:
  - Control outputs: 0 cycles from inputs.
  - Internal-flop effects: 1 cycle (E→M) or 2 cycles (E→W).
  - Counters: visible 1 cycle after the event.

Decomposition:
- Shared package core_pkg:
  - typedef fwd_sel_t (2 bits) with FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One sub-module: sat_counter (parameter W; inputs clk, reset, inc; output count), instantiated twice.

Test Plan:
- Reset sequence -> after reset with inputs 0: Forward=00, all stalls/flushes 0, counters 0.
- E→M forward: RegWriteE=1 for one cycle; next cycle Match_1E_M=1 and Match_1E_W=1 -> ForwardAE=10. Following cycle, Match_1E_W=1 only -> ForwardAE=01. Same with RegWriteE=0 -> ForwardAE stays 00.
- Load-use: MemtoRegE=1, RegWriteE=1, Match_12D_E=1 for one cycle -> StallF=StallD=FlushE=1, FlushD=0; StallCount=1 next cycle.
- PC write: PCSrcD=1 for cycle 0, PCSrcE=1 for cycle 1, others 0 -> StallF and FlushD high cycles 0–2; FlushD high cycle 3 (PCSrcW_q) with StallF=0; FlushCount=4 afterwards.
- Branch taken: BranchTakenE=1 with Match_12D_E=1, MemtoRegE=1, RegWriteE=1 -> FlushD=FlushE=StallD=1.
- Saturation with CNT_W=3: hold a load-use stall for 10 cycles -> StallCount reaches 7 and stays at 7. Reset in cycle 11 -> 0 next cycle.
